// File: rtl/pipe_latch_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_latch_skid_if
// Brief    : Valid/ready handshake bundle for a pipeline-stage latch.
// Revision : 1.0
// ============================================================================
interface pipe_latch_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  // Environment side: feeds the upstream entry and consumes the downstream one.
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  // Latch side.
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface
`default_nettype wire

// File: rtl/pipe_latch_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_latch_skid
// Brief    : Valid/ready pipeline latch with flush, control bubbling and an
//            optional 2-entry skid buffer.
// Revision : 1.0
// ============================================================================
module pipe_latch_skid #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_latch_skid_if.slave bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_stall_max = '1;

  state_t            r_state;
  logic              r_out_valid;
  logic [1:0]        r_occupancy;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_s_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [CNT_W-1:0]  r_stall;

  logic w_accept;
  logic w_consume;

  assign w_accept  = bus.in_valid & bus.in_ready;
  assign w_consume = r_out_valid & bus.out_ready;

  // With a skid slot, ready is a pure state decode so no in/out comb path exists.
  generate
    if (SKID != 0) begin : g_skid
      assign bus.in_ready = (r_state != FULL);
    end else begin : g_single
      assign bus.in_ready = !r_out_valid | bus.out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_occupancy <= 2'd0;
      r_m_data    <= '0;
      r_m_ctrl    <= CTRL_RST;
      r_s_data    <= '0;
      r_s_ctrl    <= CTRL_RST;
      r_stall     <= '0;
    end else begin
      if (r_out_valid && !bus.out_ready && (r_stall != c_stall_max))
        r_stall <= r_stall + CNT_W'(1);

      if (flush) begin
        r_state     <= EMPTY;
        r_out_valid <= 1'b0;
        r_occupancy <= 2'd0;
        r_m_data    <= '0;
        r_m_ctrl    <= CTRL_RST;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_m_data    <= bus.in_data;
              r_m_ctrl    <= bus.in_ctrl;
              r_state     <= HALF;
              r_out_valid <= 1'b1;
              r_occupancy <= 2'd1;
            end
          end
          HALF: begin
            if (w_accept && w_consume) begin
              r_m_data <= bus.in_data;
              r_m_ctrl <= bus.in_ctrl;
            end else if (w_accept) begin
              // Only reachable with a skid slot; single mode deasserts ready here.
              r_s_data    <= bus.in_data;
              r_s_ctrl    <= bus.in_ctrl;
              r_state     <= FULL;
              r_occupancy <= 2'd2;
            end else if (w_consume) begin
              r_state     <= EMPTY;
              r_out_valid <= 1'b0;
              r_occupancy <= 2'd0;
            end
          end
          FULL: begin
            if (w_consume) begin
              r_m_data    <= r_s_data;
              r_m_ctrl    <= r_s_ctrl;
              r_state     <= HALF;
              r_occupancy <= 2'd1;
            end
          end
          default: begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_occupancy <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_m_data;
  // Empty slot always presents a disabled control word, whatever M still holds.
  assign bus.out_ctrl  = r_out_valid ? r_m_ctrl : CTRL_RST;
  assign occupancy     = r_occupancy;
  assign stall_cycles  = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipe_latch_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_latch_skid
// Brief    : Directed self-checking bench for skid and single-register latches.
// Revision : 1.0
// ============================================================================
module tb_pipe_latch_skid;

  localparam logic [7:0] c_rst_a = 8'h5A;
  localparam logic [7:0] c_rst_b = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_a;
  logic        flush_b;
  logic [1:0]  occ_a;
  logic [1:0]  occ_b;
  logic [3:0]  stall_a;
  logic [15:0] stall_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_latch_skid_if #(.DATA_W(32), .CTRL_W(8)) if_a ();
  pipe_latch_skid_if #(.DATA_W(32), .CTRL_W(8)) if_b ();

  pipe_latch_skid #(
    .DATA_W(32), .CTRL_W(8), .CTRL_RST(c_rst_a), .SKID(1), .CNT_W(4)
  ) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .bus(if_a.slave),
    .occupancy(occ_a), .stall_cycles(stall_a)
  );

  pipe_latch_skid #(
    .DATA_W(32), .CTRL_W(8), .CTRL_RST(c_rst_b), .SKID(0), .CNT_W(16)
  ) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .bus(if_b.slave),
    .occupancy(occ_b), .stall_cycles(stall_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] d, input logic [7:0] c, input logic rdy);
    if_a.in_valid  = v;
    if_a.in_data   = d;
    if_a.in_ctrl   = c;
    if_a.out_ready = rdy;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic [7:0] c, input logic rdy);
    if_b.in_valid  = v;
    if_b.in_data   = d;
    if_b.in_ctrl   = c;
    if_b.out_ready = rdy;
  endtask

  logic [31:0] stream [3];

  initial begin
    stream[0] = 32'h11; stream[1] = 32'h22; stream[2] = 32'h33;
    reset = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    drive_a(1'b0, 32'h0, 8'h0, 1'b0);
    drive_b(1'b0, 32'h0, 8'h0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_valid",    32'(if_a.out_valid), 32'd0);
    check("rst_data",     if_a.out_data,       32'd0);
    check("rst_ctrl",     32'(if_a.out_ctrl),  32'h5A);
    check("rst_occ",      32'(occ_a),          32'd0);
    check("rst_stall",    32'(stall_a),        32'd0);
    check("rst_in_ready", 32'(if_a.in_ready),  32'd1);
    check("rst_occ_b",    32'(occ_b),          32'd0);

    // Streaming with downstream always ready
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, stream[i], 8'(i + 1), 1'b1);
      tick();
      check("stream_valid", 32'(if_a.out_valid), 32'd1);
      check("stream_data",  if_a.out_data,       stream[i]);
      check("stream_ctrl",  32'(if_a.out_ctrl),  32'(i + 1));
      check("stream_occ",   32'(occ_a),          32'd1);
    end
    drive_a(1'b0, 32'h0, 8'h0, 1'b1);
    tick();
    check("stream_drain_valid", 32'(if_a.out_valid), 32'd0);
    check("stream_drain_occ",   32'(occ_a),          32'd0);

    // Fill the skid buffer under stall, then release
    drive_a(1'b1, 32'h0A, 8'h0A, 1'b0);
    tick();
    check("skid_half_occ", 32'(occ_a), 32'd1);
    drive_a(1'b1, 32'h0B, 8'h0B, 1'b0);
    tick();
    check("skid_full_occ",   32'(occ_a),         32'd2);
    check("skid_full_ready", 32'(if_a.in_ready), 32'd0);
    check("skid_full_data",  if_a.out_data,      32'h0A);
    drive_a(1'b0, 32'h0, 8'h0, 1'b1);
    tick();
    check("skid_rel1_valid", 32'(if_a.out_valid), 32'd1);
    check("skid_rel1_data",  if_a.out_data,       32'h0B);
    check("skid_rel1_occ",   32'(occ_a),          32'd1);
    tick();
    check("skid_rel2_valid", 32'(if_a.out_valid), 32'd0);

    // Flush with a simultaneous incoming entry
    drive_a(1'b1, 32'h44, 8'h04, 1'b0);
    tick();
    drive_a(1'b1, 32'h0C, 8'h0C, 1'b0);
    flush_a = 1'b1;
    #1;
    check("flush_in_ready", 32'(if_a.in_ready), 32'd1);
    tick();
    flush_a = 1'b0;
    check("flush_valid", 32'(if_a.out_valid), 32'd0);
    check("flush_ctrl",  32'(if_a.out_ctrl),  32'h5A);
    check("flush_data",  if_a.out_data,       32'd0);
    check("flush_occ",   32'(occ_a),          32'd0);
    drive_a(1'b0, 32'h0, 8'h0, 1'b1);
    tick();
    check("flush_dropped", 32'(if_a.out_valid), 32'd0);

    // Stale M contents must not leak onto out_ctrl
    drive_a(1'b1, 32'h55, 8'hFF, 1'b1);
    tick();
    check("bubble_live_ctrl", 32'(if_a.out_ctrl), 32'hFF);
    drive_a(1'b0, 32'h0, 8'h0, 1'b1);
    tick();
    check("bubble_valid", 32'(if_a.out_valid), 32'd0);
    check("bubble_ctrl",  32'(if_a.out_ctrl),  32'h5A);

    // Stall counter saturates at 15 for a 4-bit width and survives flush
    drive_a(1'b1, 32'h66, 8'h06, 1'b0);
    tick();
    drive_a(1'b0, 32'h0, 8'h0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("stall_sat", 32'(stall_a), 32'd15);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("stall_after_flush", 32'(stall_a), 32'd15);
    check("stall_flush_valid", 32'(if_a.out_valid), 32'd0);
    tick();
    check("stall_hold", 32'(stall_a), 32'd15);

    // Single-register mode: ready follows !out_valid | out_ready
    drive_b(1'b1, 32'h71, 8'h71, 1'b1);
    #1;
    check("s0_ready0", 32'(if_b.in_ready), 32'd1);
    tick();
    check("s0_data0", if_b.out_data, 32'h71);
    check("s0_occ0",  32'(occ_b),    32'd1);
    drive_b(1'b1, 32'h72, 8'h72, 1'b0);
    #1;
    check("s0_ready1", 32'(if_b.in_ready), 32'd0);
    tick();
    check("s0_data1",  if_b.out_data,        32'h71);
    check("s0_valid1", 32'(if_b.out_valid),  32'd1);
    drive_b(1'b1, 32'h72, 8'h72, 1'b1);
    #1;
    check("s0_ready2", 32'(if_b.in_ready), 32'd1);
    tick();
    check("s0_data2", if_b.out_data, 32'h72);
    check("s0_occ2",  32'(occ_b),    32'd1);
    drive_b(1'b0, 32'h0, 8'h0, 1'b1);
    tick();
    check("s0_drain_valid", 32'(if_b.out_valid), 32'd0);
    check("s0_drain_ctrl",  32'(if_b.out_ctrl),  32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
